uart_rx_ctrl: RTL

Sequencing and buffering controller wrapped around the UART receive datapath.
- Generates the oversample enable tick from a programmable divisor.
- Synchronises the raw RX pin and gates the datapath through reset until the line has been idle.
- Captures each received byte into a show-ahead FIFO with per-byte parity flag, and maintains overrun/error status for the host.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_rx_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_OFF,
      ST_IDLE_WAIT,
      ST_RUN
   } rx_state_t;

   typedef struct packed {
      logic       perr;
      logic [7:0] data;
   } fifo_entry_t;

   localparam logic [7:0] CNT_SAT = 8'hFF;

   // Increment that sticks at CNT_SAT instead of wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == CNT_SAT) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO holding received bytes with their parity flag.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   push,
   input  fifo_entry_t            push_data,
   input  logic                   pop,
   output fifo_entry_t            head,
   output logic                   valid,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);

   fifo_entry_t     mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            wr_en;
   logic            rd_en;

   assign valid = (count != '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign head  = mem[rd_ptr];

   // A push into a full FIFO is only taken when the head leaves the same cycle.
   assign wr_en = push & (~full | pop) & ~flush;
   assign rd_en = pop & valid & ~flush;

   // Storage, pointers and occupancy; flush empties without touching contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencing, tick generation and byte buffering around the UART RX datapath.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE_RATE = 8,
   parameter int unsigned FIFO_DEPTH      = 16,
   parameter int unsigned IDLE_BITS       = 2,
   parameter int unsigned DIV_W           = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cfg_enable,
   input  logic [DIV_W-1:0]            cfg_divisor,
   input  logic                        cfg_flush,
   input  logic                        clr_status,
   input  logic                        rx_pin,
   output logic                        dp_rx,
   output logic                        dp_tick,
   output logic                        dp_reset,
   input  logic [7:0]                  dp_data,
   input  logic                        dp_valid,
   input  logic                        dp_parity_err,
   input  logic                        dp_frame_err,
   output logic [7:0]                  m_data,
   output logic                        m_perr,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overrun,
   output logic [7:0]                  frame_err_cnt,
   output logic [7:0]                  parity_err_cnt
);

   localparam int unsigned IDLE_TICKS = IDLE_BITS * OVERSAMPLE_RATE;
   localparam int unsigned IW         = $clog2(IDLE_TICKS + 1);

   rx_state_t        state;
   logic [IW-1:0]    idle_cnt;
   logic             sync1;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] tick_cnt;
   logic             valid_q;
   logic             ferr_q;
   logic             ferr_rise;
   logic             frame_evt;
   logic             byte_evt;
   logic             pop;
   logic             fifo_full;
   fifo_entry_t      push_entry;
   fifo_entry_t      head;

   // Two-flop synchroniser for the asynchronous RX pin, idling high.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         dp_rx <= 1'b1;
      end else begin
         sync1 <= rx_pin;
         dp_rx <= sync1;
      end
   end

   assign dp_tick = (state != ST_OFF) &&
                    ((cfg_divisor <= DIV_W'(1)) || (tick_cnt == cfg_divisor - DIV_W'(1)));

   // Oversample counter; restarts whenever the divisor is reprogrammed.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q    <= '0;
         tick_cnt <= '0;
      end else begin
         div_q <= cfg_divisor;
         if (state == ST_OFF || cfg_divisor != div_q || dp_tick) tick_cnt <= '0;
         else                                                   tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // Enable sequencing: hold the datapath in reset until the line has idled long enough.
   always_ff @(posedge clk) begin
      if (reset || !cfg_enable) begin
         state    <= ST_OFF;
         dp_reset <= 1'b1;
         idle_cnt <= '0;
      end else begin
         case (state)
            ST_OFF: begin
               state    <= ST_IDLE_WAIT;
               dp_reset <= 1'b1;
               idle_cnt <= '0;
            end
            ST_IDLE_WAIT: begin
               if (!dp_rx) begin
                  idle_cnt <= '0;
               end else if (dp_tick) begin
                  if (idle_cnt == IW'(IDLE_TICKS - 1)) begin
                     state    <= ST_RUN;
                     dp_reset <= 1'b0;
                     idle_cnt <= '0;
                  end else begin
                     idle_cnt <= idle_cnt + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               dp_reset <= 1'b0;
            end
            default: begin
               state    <= ST_OFF;
               dp_reset <= 1'b1;
               idle_cnt <= '0;
            end
         endcase
      end
   end

   // Previous datapath levels for edge detection; the datapath may hold valid high.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         valid_q <= dp_valid;
         ferr_q  <= dp_frame_err;
      end
   end

   // A frame error edge takes priority over a coincident valid edge.
   assign ferr_rise  = dp_frame_err & ~ferr_q;
   assign frame_evt  = (state == ST_RUN) & ferr_rise;
   assign byte_evt   = (state == ST_RUN) & dp_valid & ~valid_q & ~ferr_rise;
   assign pop        = m_valid & m_ready;
   assign push_entry = '{perr: dp_parity_err, data: dp_data};

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (cfg_flush),
      .push      (byte_evt),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .valid     (m_valid),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   assign m_data = head.data;
   assign m_perr = head.perr;

   // Sticky status; an error event on the clearing cycle still registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun        <= 1'b0;
         frame_err_cnt  <= '0;
         parity_err_cnt <= '0;
      end else begin
         if (byte_evt && fifo_full && !pop && !cfg_flush) overrun <= 1'b1;
         else if (clr_status)                             overrun <= 1'b0;

         if (frame_evt)       frame_err_cnt <= clr_status ? 8'd1 : sat_inc(frame_err_cnt);
         else if (clr_status) frame_err_cnt <= '0;

         if (byte_evt && dp_parity_err) parity_err_cnt <= clr_status ? 8'd1 : sat_inc(parity_err_cnt);
         else if (clr_status)           parity_err_cnt <= '0;
      end
   end

endmodule
